// File: rtl/vc_ram_queue.sv
// vc_ram_queue: val/rdy FIFO over a 1W/1R flop RAM; define VC_RAM_QUEUE_BYPASS_EN for a bypass queue.
module vc_ram_queue #(
  parameter int DATA_SZ = 1,
  parameter int ENTRIES = 2,
  parameter int ADDR_SZ = 1
)(
  input  logic               clk,
  input  logic               reset_p,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [DATA_SZ-1:0] enq_bits,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [DATA_SZ-1:0] deq_bits,
  output logic [ADDR_SZ:0]   num_free_entries
);
  localparam logic [ADDR_SZ:0]   DEPTH = (ADDR_SZ+1)'(ENTRIES);
  localparam logic [ADDR_SZ-1:0] LAST  = ADDR_SZ'(ENTRIES-1);
  logic [DATA_SZ-1:0] mem_q [ENTRIES];
  logic [ADDR_SZ-1:0] enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d, enq_ptr_inc, deq_ptr_inc;
  logic               full_q, full_d, empty, enq_fire, deq_fire, wr_en, rd_adv, pass;
  logic [ADDR_SZ:0]   occ;
  always_comb begin
    empty = (enq_ptr_q == deq_ptr_q) && !full_q;
    enq_rdy = !full_q;
`ifdef VC_RAM_QUEUE_BYPASS_EN
    deq_val = !empty || enq_val;
    deq_bits = empty ? enq_bits : mem_q[deq_ptr_q];
`else
    deq_val = !empty;
    deq_bits = mem_q[deq_ptr_q];
`endif
    enq_fire = enq_val && enq_rdy;
    deq_fire = deq_val && deq_rdy;
`ifdef VC_RAM_QUEUE_BYPASS_EN
    pass = empty && enq_fire && deq_fire;
`else
    pass = 1'b0;
`endif
    // a passed-through entry never touches the RAM or the pointers
    wr_en = enq_fire && !pass;
    rd_adv = deq_fire && !pass;
    enq_ptr_inc = (enq_ptr_q == LAST) ? '0 : enq_ptr_q + ADDR_SZ'(1);
    deq_ptr_inc = (deq_ptr_q == LAST) ? '0 : deq_ptr_q + ADDR_SZ'(1);
    enq_ptr_d = wr_en ? enq_ptr_inc : enq_ptr_q;
    deq_ptr_d = rd_adv ? deq_ptr_inc : deq_ptr_q;
    full_d = (wr_en && !rd_adv) ? (enq_ptr_inc == deq_ptr_q) :
             (rd_adv && !wr_en) ? 1'b0 : full_q;
    occ = {1'b0, enq_ptr_q} - {1'b0, deq_ptr_q} + ((enq_ptr_q < deq_ptr_q) ? DEPTH : '0);
    num_free_entries = full_q ? '0 : DEPTH - occ;
  end
  always_ff @(posedge clk)
    if (wr_en && !reset_p) mem_q[enq_ptr_q] <= enq_bits;
  always_ff @(posedge clk) begin
    if (reset_p) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      full_q <= 1'b0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      full_q <= full_d;
    end
  end
endmodule
